// File: rtl/dot_acc.sv
// Streaming dot-product accumulator: sums signed partial-sum terms until in_last, then holds the result.
// Define DOT_ACC_SAT_EN to clamp overflowing adds and report overflow; otherwise adds wrap and out_ovf is 0.
module dot_acc #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_ovf
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state;
  logic [31:0]      acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic             transfer;
  logic [31:0]      sum_raw;
  logic [31:0]      acc_next;
  logic [CNT_W-1:0] cnt_next;
  logic             term_ovf;
  logic             ovf_next;

  assign out_valid = (state == HOLD);
  assign in_ready  = !out_valid || out_ready;
  assign transfer  = in_valid && in_ready;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    sum_raw  = acc + in_data;
    acc_next = sum_raw;
    term_ovf = 1'b0;
`ifdef DOT_ACC_SAT_EN
    // Signed overflow: operands agree in sign but the sum does not.
    term_ovf = (acc[31] == in_data[31]) && (sum_raw[31] != acc[31]);
    if (term_ovf) acc_next = acc[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    ovf_next = ovf | term_ovf;
    cnt_next = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ACCUM;
      acc      <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      out_data <= '0;
      out_cnt  <= '0;
      out_ovf  <= 1'b0;
    end else if (transfer) begin
      if (in_last) begin
        out_data <= acc_next;
        out_cnt  <= cnt_next;
        out_ovf  <= ovf_next;
        acc      <= '0;
        cnt      <= '0;
        ovf      <= 1'b0;
        state    <= HOLD;
      end else begin
        // A non-last transfer in HOLD implies out_ready, so the old result retires here.
        acc      <= acc_next;
        cnt      <= cnt_next;
        ovf      <= ovf_next;
        state    <= ACCUM;
      end
    end else if (state == HOLD && out_ready) begin
      state <= ACCUM;
    end
  end

endmodule

// File: tb/tb_dot_acc.sv
// Scoreboard bench for dot_acc: the driver pushes reference results computed from the accepted
// terms with plain integer arithmetic; an independent monitor compares whatever the DUT presents.
module tb_dot_acc;

  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [31:0] data;
    logic [31:0] cnt;
    logic [31:0] ovf;
  } result_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic [31:0]      in_data = '0;
  logic             in_last = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_data;
  logic [CNT_W-1:0] out_cnt;
  logic             out_ovf;

  dot_acc #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_cnt(out_cnt), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  result_t     exp_q[$];
  int          terms[$];
  bit          mon_en = 1'b0;
  bit          pend_acc = 1'b0;
  bit          pend_rst = 1'b0;
  logic [31:0] pend_d = '0;
  bit          pend_l = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the result of a vector is the (per-add clamped or wrapped) sum of its terms.
  task automatic model_accept(input logic [31:0] d, input bit l);
    result_t r;
    longint  s;
    int      w;
    bit      ov;
    terms.push_back(int'(d));
    if (!l) return;
    s = 0; w = 0; ov = 1'b0;
    foreach (terms[i]) begin
      s = s + longint'(terms[i]);
      if (s > 64'sd2147483647) begin s = 64'sd2147483647; ov = 1'b1; end
      else if (s < -64'sd2147483648) begin s = -64'sd2147483648; ov = 1'b1; end
      w = w + terms[i];
    end
`ifdef DOT_ACC_SAT_EN
    r.data = 32'(s);
    r.ovf  = {31'b0, ov};
`else
    r.data = 32'(w);
    r.ovf  = 32'd0;
`endif
    r.cnt = (terms.size() > CNT_MAX) ? CNT_MAX : terms.size();
    exp_q.push_back(r);
    terms.delete();
  endtask

  // One clock of stimulus; the effect of the previous cycle's handshake is applied at the edge.
  task automatic step(input bit v, input logic [31:0] d, input bit l, input bit r, input bit rst);
    @(posedge clk);
    if (pend_rst) begin
      terms.delete();
      exp_q.delete();
    end else if (pend_acc) begin
      model_accept(pend_d, pend_l);
    end
    #1;
    reset = rst; in_valid = v; in_data = d; in_last = l; out_ready = r;
    @(negedge clk);
    pend_rst = rst;
    pend_acc = v && (in_ready === 1'b1) && !rst;
    pend_d   = d;
    pend_l   = l;
  endtask

  // Monitor: compares presented outputs and handshake signals against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      check("in_ready", {31'b0, in_ready}, {31'b0, (exp_q.size() == 0) || out_ready});
      check("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
      if (out_valid === 1'b1 && exp_q.size() != 0) begin
        check("out_data", out_data, exp_q[0].data);
        check("out_cnt", 32'(out_cnt), exp_q[0].cnt);
        check("out_ovf", {31'b0, out_ovf}, exp_q[0].ovf);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    mon_en = 1'b1;
    // First cycle after reset release.
    step(0, 0, 0, 0, 0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_cnt", 32'(out_cnt), 32'd0);
    check("rst_out_ovf", {31'b0, out_ovf}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // 3 + 5 + -2 = 6
    step(1, 32'd3, 0, 1, 0);
    step(1, 32'd5, 0, 1, 0);
    step(1, -32'sd2, 1, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // Held result with out_ready low, then back-to-back single-term vector.
    step(1, 32'd10, 0, 1, 0);
    step(1, 32'd20, 1, 0, 0);
    repeat (4) step(1, 32'd99, 0, 0, 0);
    step(1, 32'd7, 1, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);

    // Overflow boundary.
    step(1, 32'h7FFF_FFF0, 0, 1, 0);
    step(1, 32'h0000_0020, 1, 1, 0);
    step(0, 0, 0, 1, 0);
    step(1, 32'h8000_0001, 0, 1, 0);
    step(1, 32'hFFFF_FFF0, 0, 1, 0);
    step(1, 32'h0000_0005, 1, 1, 0);
    step(0, 0, 0, 1, 0);

    // Reset mid-vector (with a term offered during reset), then a fresh vector.
    step(1, 32'd4, 0, 1, 0);
    step(1, 32'd4, 0, 1, 0);
    step(1, 32'd4, 0, 1, 1);
    step(1, 32'd1, 0, 1, 0);
    step(1, 32'd1, 1, 1, 0);
    step(0, 0, 0, 1, 0);

    // Term-counter saturation.
    for (int i = 0; i < 300; i++) step(1, 32'd1, i == 299, 1, 0);
    step(0, 0, 0, 1, 0);

    // Randomized traffic with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       d = 32'($urandom_range(0, 200)) - 32'd100;
        1:       d = $urandom;
        2:       d = 32'h7FFF_FF00 + 32'($urandom_range(0, 255));
        default: d = 32'h8000_0000 + 32'($urandom_range(0, 255));
      endcase
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0, 0);
    end

    for (int i = 0; i < 30 && (exp_q.size() != 0 || pend_acc); i++) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    check("drain", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dot_acc.md
DOT_ACC -- requirements
Module: dot_acc

Interface
REQ-001 SHALL provide parameter CNT_W, default 8, width of the term counter.
REQ-002 SHALL provide port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port in_valid  input  1  partial-sum term present on in_data.
REQ-005 SHALL provide port in_data  input  32  signed partial sum (A1*B1+A2*B2 from the multiply-add stage).
REQ-006 SHALL provide port in_last  input  1  marks the final term of the current vector; sampled with in_valid.
REQ-007 SHALL provide port in_ready  output  1  block accepts a term this cycle.
REQ-008 SHALL provide port out_valid  output  1  out_data/out_cnt/out_ovf hold a finished dot product.
REQ-009 SHALL provide port out_ready  input  1  consumer takes the result this cycle.
REQ-010 SHALL provide port out_data  output  32  signed dot-product result.
REQ-011 SHALL provide port out_cnt  output  CNT_W  number of terms accumulated into out_data.
REQ-012 SHALL provide port out_ovf  output  1  signed overflow occurred in this vector.

Function
REQ-013 SHALL accept a term ("transfer") exactly on a clk edge where in_valid && in_ready.
REQ-014 SHALL drive in_ready = !out_valid || out_ready (combinational; no other stall source).
REQ-015 SHALL implement states ACCUM (collecting terms) and HOLD (result valid); out_valid = (state == HOLD).
REQ-016 SHALL, on a non-last transfer, set acc <= acc + in_data, cnt <= cnt + 1, ovf <= ovf | term_overflow, staying in ACCUM.
REQ-017 SHALL, on a last transfer, load out_data <= acc + in_data, out_cnt <= cnt + 1, out_ovf <= ovf | term_overflow, clear acc/cnt/ovf to 0, enter HOLD; latency in_last transfer -> out_valid = 1 cycle.
REQ-018 SHALL, in HOLD with out_ready = 0, hold out_data/out_cnt/out_ovf stable and keep in_ready = 0.
REQ-019 SHALL, in HOLD with out_ready = 1 and no transfer, return to ACCUM next cycle.
REQ-020 SHALL, in HOLD with out_ready = 1 and a simultaneous transfer, retire the old result and process the new term per REQ-016/017 in the same edge (last term -> remain in HOLD with new result; no bubble).
REQ-021 SHALL saturate cnt at 2^CNT_W-1 (no wrap); out_cnt reports the saturated value.
REQ-022 SHALL treat a single-term vector (in_last on first term) as out_data = in_data, out_cnt = 1.
REQ-023 SHALL define term_overflow as signed overflow of the 32-bit add acc + in_data (operands same sign, sum sign differs).
REQ-024 SHALL ignore in_data/in_last when no transfer occurs.

Reset
REQ-025 SHALL, when reset = 1 at a clk edge, set state ACCUM, acc = 0, cnt = 0, ovf = 0, out_data = 0, out_cnt = 0, out_ovf = 0, out_valid = 0, discarding any partial vector or held result; reset has priority over all transfers.
REQ-026 SHALL drive in_ready = 1 in the first cycle after reset is released.

Configuration
REQ-027 SHALL use macro DOT_ACC_SAT_EN to select overflow handling.
REQ-028 SHALL, with DOT_ACC_SAT_EN defined, clamp each overflowing add to 32'h7FFFFFFF (positive) or 32'h80000000 (negative) and report out_ovf per REQ-017.
REQ-029 SHALL, without DOT_ACC_SAT_EN, wrap all adds modulo 2^32 and tie out_ovf to 0.

Verification
REQ-030 SHALL cover: reset, then terms 3, 5, -2(last) with out_ready=1 -> one cycle after last, out_valid=1, out_data=6, out_cnt=3, out_ovf=0.
REQ-031 SHALL cover: result held with out_ready=0 for 4 cycles while in_valid=1 -> in_ready=0, out_data/out_cnt unchanged, no terms consumed.
REQ-032 SHALL cover: result in HOLD, out_ready=1 with simultaneous single last term 7 -> next cycle out_valid=1, out_data=7, out_cnt=1, no idle cycle.
REQ-033 SHALL cover: terms 32'h7FFFFFF0, 32'h20(last) -> SAT_EN: out_data=32'h7FFFFFFF, out_ovf=1; no SAT_EN: out_data=32'h80000010, out_ovf=0.
REQ-034 SHALL cover: reset asserted after 2 of 4 terms, then vector 1, 1(last) -> out_data=2, out_cnt=2.
REQ-035 SHALL cover: 300 terms of 1 with CNT_W=8 -> out_cnt=255, out_data=300.
